// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bus between a UART receiver, its RX FIFO and the consumer.
// master drives writes/pops/clear; slave is the FIFO returning head byte and status.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic          ovf_clr;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, rd_en, ovf_clr,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ovf_clr,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with sticky overflow flag.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;
  logic        ovf;

  // Extra MSB on each pointer separates full from empty
  assign bus.empty = (wr_ptr == rd_ptr);
  assign bus.full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
  assign bus.count = wr_ptr - rd_ptr;
  assign bus.overflow = ovf;

  assign do_wr = bus.wr_en && !bus.full;
  assign do_rd = bus.rd_en && !bus.empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
  end

  // A dropped write beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)                          ovf <= 1'b0;
    else if (bus.wr_en && bus.full)   ovf <= 1'b1;
    else if (bus.ovf_clr)             ovf <= 1'b0;
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign bus.rd_data = bus.empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
`else
  logic [7:0] rd_q;

  always_ff @(posedge clk) begin
    if (rst)        rd_q <= 8'h00;
    else if (do_rd) rd_q <= mem[rd_ptr[AW-1:0]];
  end

  assign bus.rd_data = rd_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based model, directed + random traffic.
// Build with and without UART_RX_FIFO_FWFT_EN.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;
  bit         mon_on = 1'b0;
  bit         pend = 1'b0;
  bit         pend_rst = 1'b0;
  logic [7:0] hold_val = 8'h00;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Check status after the previous edge, then drive the next cycle
  task automatic step(bit w, logic [7:0] d, bit r, bit c, bit rs);
    bit was_full;
    bit was_empty;
    @(posedge clk); #1;
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == DEPTH);
    chk("count", bus.count, q.size());
    chk("overflow", bus.overflow, m_ovf);
    rst = rs;
    bus.wr_en = w;
    bus.wr_data = d;
    bus.rd_en = r;
    bus.ovf_clr = c;
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (r && !was_empty) exp_q.push_back(q.pop_front());
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
  endtask

  task automatic wr(logic [7:0] d);
    step(1, d, 0, 0, 0);
  endtask

  task automatic pop(int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1, 0, 0);
  endtask

  // Monitor: compares every byte the FIFO hands out against the scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
`ifdef UART_RX_FIFO_FWFT_EN
      if (bus.rd_en && !bus.empty && !rst) begin
        if (exp_q.size() == 0) chk("pop_extra", 1, 0);
        else chk("fwft_data", bus.rd_data, exp_q.pop_front());
      end
`else
      if (pend) begin
        if (exp_q.size() == 0) chk("pop_extra", 1, 0);
        else hold_val = exp_q.pop_front();
      end else if (pend_rst) begin
        hold_val = 8'h00;
      end
      chk("rd_data", bus.rd_data, hold_val);
      pend = bus.rd_en && !bus.empty && !rst;
      pend_rst = rst;
`endif
    end
  end

  initial begin
    int wp;
    int rp;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en = 1'b0;
    bus.ovf_clr = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    step(0, 8'h00, 0, 0, 1);
    idle(2);

    // Single byte round trip
    wr(8'h55);
    idle(1);
`ifdef UART_RX_FIFO_FWFT_EN
    chk("fwft_head", bus.rd_data, 8'h55);
`endif
    idle(1);
    pop(1);
    idle(2);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    wr(8'hAA);
    idle(1);
    pop(DEPTH);
    idle(1);
    step(0, 8'h00, 0, 1, 0);
    idle(1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) wr(8'($urandom));
    pop(10);
    for (int i = 0; i < 12; i++) wr(8'(8'h30 + i));
    pop(12);
    idle(2);

    // Steady-state streaming at count 5
    for (int i = 0; i < 5; i++) wr(8'(i));
    for (int i = 5; i < 25; i++) step(1, 8'(i), 1, 0, 0);
    pop(5);
    idle(1);

    // Full with simultaneous write and pop, with clear coinciding
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h80 + i));
    step(1, 8'hEE, 1, 1, 0);
    idle(1);
    pop(8);
    idle(1);

    // Reset mid-stream with count 7 and overflow set
    step(0, 8'h00, 0, 0, 1);
    idle(2);
    for (int i = 0; i < DEPTH + 1; i++) wr(8'(8'hC0 + i));
    step(0, 8'h00, 0, 1, 0);
    idle(1);
    pop(DEPTH);

    // Pops while empty
    pop(3);
    step(1, 8'h77, 1, 0, 0);
    pop(2);
    idle(1);

    // Randomized traffic with shifting write/read bias
    for (int blk = 0; blk < 12; blk++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 40; i++) begin
        step($urandom_range(0, 99) < wp, 8'($urandom),
             $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 5,
             $urandom_range(0, 199) == 0);
      end
    end

    pop(DEPTH + 2);
    idle(3);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of byte entries; must be a power of two, at least 2.
REQ-002 SHALL have parameter AW, default 4, meaning pointer width, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  one-cycle strobe from the UART receiver: byte complete.
REQ-006 SHALL have port wr_data  input  8  received byte, valid when wr_en=1.
REQ-007 SHALL have port rd_en  input  1  pop request from the consumer (LED/command logic).
REQ-008 SHALL have port rd_data  output  8  head byte.
REQ-009 SHALL have port empty  output  1  no stored bytes.
REQ-010 SHALL have port full  output  1  DEPTH bytes stored.
REQ-011 SHALL have port count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: a write was dropped while full.
REQ-013 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-014 SHALL store bytes in a DEPTH x 8 register array addressed by AW+1-bit write/read pointers; the MSB is the wrap bit.
REQ-015 SHALL derive empty when the pointers are equal, full when the low AW bits are equal and the MSBs differ, and count as wr_ptr minus rd_ptr modulo 2^(AW+1).
REQ-016 SHALL accept a write when wr_en=1 and full=0: store wr_data at wr_ptr, increment wr_ptr, and update count/empty/full on the next cycle.
REQ-017 SHALL drop a write when wr_en=1 and full=1, leave the contents and pointers unchanged, and set overflow=1 on the next edge.
REQ-018 SHALL perform a pop when rd_en=1 and empty=0 by incrementing rd_ptr; rd_en=1 while empty SHALL be ignored with no pointer change.
REQ-019 SHALL accept both operations when wr_en and rd_en are both 1 and the FIFO is neither empty nor full; count SHALL be unchanged.
REQ-020 When full, simultaneous wr_en and rd_en SHALL perform only the pop, drop the write, and set overflow.
REQ-021 When empty, simultaneous wr_en and rd_en SHALL perform only the write.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 in the low bits and toggle the MSB, with no gap or duplicate byte.
REQ-023 overflow SHALL remain 1 until ovf_clr=1; if ovf_clr and a dropped write coincide, overflow SHALL be 1 (set wins).
REQ-024 Full throughput SHALL be one write and one read per cycle; write-to-empty-deassert latency SHALL be 1 cycle.

Reset
REQ-025 On a clk edge with rst=1: pointers=0, empty=1, full=0, count=0, overflow=0, rd_data=8'h00; storage array not cleared.
REQ-026 rst SHALL override wr_en/rd_en/ovf_clr in the same cycle; reset mid-stream discards all stored bytes.

Configuration
REQ-027 With macro UART_RX_FIFO_FWFT_EN defined: first-word-fall-through; rd_data SHALL equal the head entry whenever empty=0 (combinational read of array[rd_ptr]), and rd_en acknowledges and consumes it.
REQ-028 Without UART_RX_FIFO_FWFT_EN: rd_data SHALL be a register loaded with array[rd_ptr] on an accepted pop, valid the cycle after rd_en, and SHALL hold its value otherwise.

Verification
REQ-029 Write 8'h55 once, then idle -> empty=0, count=1 on the next cycle; pop -> byte 8'h55 (FWFT: visible before the pop; non-FWFT: one cycle after rd_en), then empty=1.
REQ-030 Write 0x00..0x0F (DEPTH=16) -> full=1, count=16; a 17th write of 0xAA -> overflow=1, contents intact; 16 pops return 0x00..0x0F in order.
REQ-031 Fill 10, pop 10, write 12 (pointers wrap) -> 12 pops return the written order; count returns to 0; empty=1.
REQ-032 Hold count=5 with wr_en=rd_en=1 for 20 cycles using an incrementing pattern -> count stays 5 and the output sequence is contiguous; with full, simultaneous write+pop -> count=15, overflow=1.
REQ-033 Assert rst with count=7 and overflow=1 -> next cycle count=0, empty=1, overflow=0; ovf_clr alone clears overflow in 1 cycle.
REQ-034 Pop while empty -> pointers unchanged and count stays 0; run the bench both with and without UART_RX_FIFO_FWFT_EN.
